// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save stream accumulator: FSM encoding and
// operand extension helper.
package csa_pkg;

  // Widest accumulator the extension helper supports (SIZE+CNT_W must fit).
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Extend the low 'size' bits of data to MAX_W bits, sign- or zero-filled.
  // Callers truncate the result to their own accumulator width.
  function automatic logic [MAX_W-1:0] ext_operand(input logic [MAX_W-1:0] data,
                                                   input int               size,
                                                   input logic             signed_mode);
    logic [MAX_W-1:0] res;
    logic             msb;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == size - 1) msb = data[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      res[i] = (i < size) ? data[i] : (signed_mode & msb);
    end
    return res;
  endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// 3:2 carry-save compressor. The carry vector is already shifted into its
// weight position, so s + c == x + y + z (mod 2**W).
module csa_compress_3to2 #(
  parameter int W = 40
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_c
);

  logic [W-1:0] w_maj;

  assign w_maj = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
  assign o_s   = i_x ^ i_y ^ i_z;
  // The carry out of the top bit falls off: the total is defined mod 2**W.
  assign o_c   = w_maj << 1;

endmodule

// File: rtl/csa_stream_accumulator.sv
// Packet accumulator: folds one operand per accepted beat into a redundant
// (sum, carry) pair, resolves it once per packet and presents the total.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ACC   | accepting operand beats, in_ready=1
//   ST_RESOLVE | one cycle: carry-propagate add of the (S, C) pair
//   ST_DONE  | result presented on out_* until out_ready
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE+CNT_W-1:0] out_sum,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf
);

  localparam int              W       = SIZE + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [W-1:0]     r_s;
  logic [W-1:0]     r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic [W-1:0]     w_x;
  logic [W-1:0]     w_s_nxt;
  logic [W-1:0]     w_c_nxt;
  logic             w_accept;

  assign w_x      = W'(ext_operand(MAX_W'(in_data), SIZE, SIGNED != 0));
  assign w_accept = in_valid & r_in_ready;

  csa_compress_3to2 #(.W(W)) u_compress (
    .i_x (r_s),
    .i_y (r_c),
    .i_z (w_x),
    .o_s (w_s_nxt),
    .o_c (w_c_nxt)
  );

  // Packet FSM: accumulate beats, resolve once, hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_s <= w_s_nxt;
            r_c <= w_c_nxt;
            // Count saturates; a beat beyond the maximum only flags overflow.
            if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
            else                  r_cnt <= r_cnt + CNT_W'(1);
            if (in_last) begin
              r_state    <= ST_RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          r_out_sum   <= r_s + r_c;
          r_out_count <= r_cnt;
          r_out_ovf   <= r_ovf;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            // Clear the packet state here so ACC starts clean next cycle;
            // in_ready only rises after this edge, so no beat lands now.
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ACC;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: one unsigned and one signed instance,
// scoreboard queues filled at issue time, drained by a result monitor.
`timescale 1ns/1ps
module tb_csa_stream_accumulator;

  localparam int SIZE  = 32;
  localparam int CNT_W = 8;
  localparam int W     = SIZE + CNT_W;

  typedef struct packed {
    logic [W-1:0]     sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic             rst_n     [2];
  logic             in_valid  [2];
  logic             in_ready  [2];
  logic [SIZE-1:0]  in_data   [2];
  logic             in_last   [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [W-1:0]     out_sum   [2];
  logic [CNT_W-1:0] out_count [2];
  logic             out_ovf   [2];

  bit   hold    [2];
  bit   rand_bp [2];
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [31:0] pkt[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csa_stream_accumulator #(.SIZE(SIZE), .CNT_W(CNT_W), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_count(out_count[0]),
    .out_ovf(out_ovf[0])
  );

  csa_stream_accumulator #(.SIZE(SIZE), .CNT_W(CNT_W), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(out_sum[1]), .out_count(out_count[1]),
    .out_ovf(out_ovf[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic push_lit(input int k, input logic [W-1:0] s, input logic [CNT_W-1:0] c,
                          input logic o);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.ovf = o;
    push(k, e);
  endtask

  // Reference: the packet total as plain integer arithmetic, truncated to W.
  function automatic exp_t model(input int k);
    longint      acc;
    logic [63:0] u;
    exp_t        e;
    acc = 0;
    foreach (pkt[i]) begin
      if (k == 1) acc += longint'($signed(pkt[i]));
      else        acc += longint'({32'd0, pkt[i]});
    end
    u     = acc;
    e.sum = u[W-1:0];
    e.cnt = (pkt.size() > 255) ? 8'd255 : 8'(pkt.size());
    e.ovf = (pkt.size() > 255);
    return e;
  endfunction

  // Result monitor: chooses out_ready, then scores any handshake it will complete.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      if (hold[k])         out_ready[k] = 1'b0;
      else if (rand_bp[k]) out_ready[k] = ($urandom_range(0, 2) != 0);
      else                 out_ready[k] = 1'b1;
      if (rst_n[k] === 1'b1 && out_valid[k] === 1'b1 && out_ready[k]) begin
        if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          fail_now($sformatf("unexpected_result_%0d", k));
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("out_sum_%0d", k),   64'(out_sum[k]),   64'(e.sum));
          check($sformatf("out_count_%0d", k), 64'(out_count[k]), 64'(e.cnt));
          check($sformatf("out_ovf_%0d", k),   64'(out_ovf[k]),   64'(e.ovf));
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_beat(input int k, input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_last[k]  = last;
    while (!in_ready[k] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[k]) fail_now($sformatf("beat_accept_timeout_%0d", k));
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_data[k]  = $urandom;
    in_last[k]  = 1'($urandom);
  endtask

  task automatic send_pkt(input int k, input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      send_beat(k, pkt[i], (i == pkt.size() - 1));
    end
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!out_valid[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid[k]) fail_now($sformatf("out_valid_timeout_%0d", k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; in_last[k] = 1'b0;
      hold[k] = 1'b0; rand_bp[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", 64'(out_valid[k]), 64'd0);
      check("rst_out_sum",   64'(out_sum[k]),   64'd0);
      check("rst_out_count", 64'(out_count[k]), 64'd0);
      check("rst_out_ovf",   64'(out_ovf[k]),   64'd0);
      rst_n[k] = 1'b1;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) check("rst_in_ready", 64'(in_ready[k]), 64'd1);

    // Basic unsigned packet plus the latency through RESOLVE.
    pkt = {32'd5, 32'd7, 32'd9};
    push_lit(0, 40'd21, 8'd3, 1'b0);
    send_pkt(0, 1'b0);
    check("lat_resolve_valid", 64'(out_valid[0]), 64'd0);
    check("lat_resolve_ready", 64'(in_ready[0]),  64'd0);
    @(posedge clk); #1;
    check("lat_done_valid", 64'(out_valid[0]), 64'd1);

    // Single all-ones beat: zero-extended on the unsigned side.
    pkt = {32'hFFFF_FFFF};
    push_lit(0, 40'h00_FFFF_FFFF, 8'd1, 1'b0);
    send_pkt(0, 1'b0);

    // Counter boundary: 255 beats fits, 256 overflows.
    pkt.delete();
    repeat (255) pkt.push_back(32'hFFFF_FFFF);
    push_lit(0, 40'hFE_FFFF_FF01, 8'd255, 1'b0);
    send_pkt(0, 1'b0);
    pkt.push_back(32'hFFFF_FFFF);
    push_lit(0, 40'hFF_FFFF_FF00, 8'd255, 1'b1);
    send_pkt(0, 1'b0);

    // Signed packets.
    pkt = {32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFC};
    push_lit(1, 40'hFF_FFFF_FFFA, 8'd3, 1'b0);
    send_pkt(1, 1'b0);
    pkt = {32'hFFFF_FFFF};
    push_lit(1, 40'hFF_FFFF_FFFF, 8'd1, 1'b0);
    send_pkt(1, 1'b0);

    // Consumer stall with input pressure: nothing accepted, outputs held.
    hold[0] = 1'b1;
    pkt = {32'd10, 32'd20};
    push_lit(0, 40'd30, 8'd2, 1'b0);
    send_pkt(0, 1'b0);
    wait_valid(0);
    in_valid[0] = 1'b1;
    in_last[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data[0] = $urandom;
      @(posedge clk); #1;
      check("stall_in_ready",  64'(in_ready[0]),  64'd0);
      check("stall_out_valid", 64'(out_valid[0]), 64'd1);
      check("stall_out_sum",   64'(out_sum[0]),   64'd30);
      check("stall_out_count", 64'(out_count[0]), 64'd2);
    end
    in_valid[0] = 1'b0;
    hold[0]     = 1'b0;
    pkt = {32'd2, 32'd2};
    push_lit(0, 40'd4, 8'd2, 1'b0);
    send_pkt(0, 1'b0);
    wait_valid(0);
    @(posedge clk); #1;

    // Reset mid-packet discards the partial accumulation.
    send_beat(0, 32'd100, 1'b0);
    send_beat(0, 32'd200, 1'b0);
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_out_sum",   64'(out_sum[0]),   64'd0);
    check("midrst_out_count", 64'(out_count[0]), 64'd0);
    check("midrst_out_ovf",   64'(out_ovf[0]),   64'd0);
    check("midrst_in_ready",  64'(in_ready[0]),  64'd1);
    pkt = {32'd1};
    push_lit(0, 40'd1, 8'd1, 1'b0);
    send_pkt(0, 1'b0);

    // Randomized packets with gaps and back-pressure on both instances.
    rand_bp[0] = 1'b1;
    rand_bp[1] = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int k;
      int len;
      k   = it % 2;
      len = $urandom_range(1, 12);
      pkt.delete();
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 3))
          0:       pkt.push_back(32'hFFFF_FFFF);
          1:       pkt.push_back(32'h8000_0000);
          2:       pkt.push_back($urandom_range(0, 15));
          default: pkt.push_back($urandom);
        endcase
      end
      push(k, model(k));
      send_pkt(k, 1'b1);
    end

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_q0", 64'(exp_q0.size()), 64'd0);
    check("drain_q1", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
